// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode type, default sizes and duty slice helper for the PWM block
package pwm_pkg;
  typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_e;
  localparam int WIDTH_DEF = 8;
  localparam int CHANNELS_DEF = 4;
  localparam int PRE_W_DEF = 8;
  function automatic int duty_lsb(input int ch, input int width);
    return ch * width;
  endfunction
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: clock divider producing a tick every Prescale+1 clocks
module pwm_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Clear,
  input  logic [PRE_W-1:0] Prescale,
  output logic             Tick
);
  logic [PRE_W-1:0] cnt_q, cnt_d;
  // >= rather than == so a lowered Prescale wraps on the next clock
  always_comb begin
    Tick = !Clear && (cnt_q >= Prescale);
    cnt_d = (Clear || Tick) ? '0 : cnt_q + 1'b1;
  end
  // divider state
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with shared counter and double-buffered top/mode/duty
module pwm_multi import pwm_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int PRE_W = PRE_W_DEF
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  input  logic                      Enable,
  input  logic [PRE_W-1:0]          Prescale,
  input  logic [WIDTH-1:0]          Top,
  input  logic                      Center,
  input  logic [CHANNELS*WIDTH-1:0] Duty,
  input  logic                      Load,
  output logic [CHANNELS-1:0]       Y,
  output logic [WIDTH-1:0]          Q,
  output logic                      PeriodStart,
  output logic                      Pending
);
  logic tick, top_hit, boundary;
  logic [WIDTH-1:0] q_q, q_d, edge_nx, center_nx, step_nx;
  logic dir_q, dir_d, restart_q, restart_d, ps_q, ps_d, pend_q, pend_d;
  logic [CHANNELS-1:0] y_q, y_d;
  logic [WIDTH-1:0] sh_top_q, sh_top_d, act_top_q, act_top_d;
  pwm_mode_e sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
  logic [CHANNELS*WIDTH-1:0] sh_duty_q, sh_duty_d, act_duty_q, act_duty_d;

  pwm_prescaler #(.PRE_W(PRE_W)) u_pre (
    .Clock(Clock),
    .Resetn(Resetn),
    .Clear(!Enable),
    .Prescale(Prescale),
    .Tick(tick)
  );

  // counter stepping; a boundary is any tick that lands Q on 0 (restart after enable included)
  always_comb begin
    top_hit = q_q >= act_top_q;
    edge_nx = top_hit ? '0 : q_q + 1'b1;
    center_nx = (dir_q || top_hit) ? ((q_q == '0) ? '0 : q_q - 1'b1) : q_q + 1'b1;
    step_nx = restart_q ? '0 : (act_mode_q == PWM_CENTER) ? center_nx : edge_nx;
    boundary = tick && (step_nx == '0);
    q_d = !Enable ? '0 : tick ? step_nx : q_q;
    dir_d = (!Enable || boundary) ? 1'b0 : tick ? ((act_mode_q == PWM_CENTER) && (dir_q || top_hit)) : dir_q;
    restart_d = !Enable ? 1'b1 : tick ? 1'b0 : restart_q;
    ps_d = boundary;
  end

  // shadow captures on Load; active takes the old shadow only at a boundary
  always_comb begin
    pend_d = Load || (pend_q && !boundary);
    sh_top_d = Load ? Top : sh_top_q;
    sh_mode_d = Load ? pwm_mode_e'(Center) : sh_mode_q;
    sh_duty_d = Load ? Duty : sh_duty_q;
    act_top_d = (boundary && pend_q) ? sh_top_q : act_top_q;
    act_mode_d = (boundary && pend_q) ? sh_mode_q : act_mode_q;
    act_duty_d = (boundary && pend_q) ? sh_duty_q : act_duty_q;
  end

  // in center mode the Q==duty step counts as high on the descending half so the pulse is symmetric
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] duty;
    assign duty = act_duty_q[duty_lsb(i, WIDTH) +: WIDTH];
    assign y_d[i] = Enable && ((q_q < duty) ||
      ((act_mode_q == PWM_CENTER) && (duty != '0) && (q_q == duty) && (dir_q || top_hit)));
  end

  // state registers
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      q_q <= '0;
      dir_q <= 1'b0;
      restart_q <= 1'b0;
      ps_q <= 1'b0;
      pend_q <= 1'b0;
      y_q <= '0;
      sh_top_q <= '1;
      act_top_q <= '1;
      sh_mode_q <= PWM_EDGE;
      act_mode_q <= PWM_EDGE;
      sh_duty_q <= '0;
      act_duty_q <= '0;
    end else begin
      q_q <= q_d;
      dir_q <= dir_d;
      restart_q <= restart_d;
      ps_q <= ps_d;
      pend_q <= pend_d;
      y_q <= y_d;
      sh_top_q <= sh_top_d;
      act_top_q <= act_top_d;
      sh_mode_q <= sh_mode_d;
      act_mode_q <= act_mode_d;
      sh_duty_q <= sh_duty_d;
      act_duty_q <= act_duty_d;
    end

  assign Y = y_q;
  assign Q = q_q;
  assign PeriodStart = ps_q;
  assign Pending = pend_q;
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed self-checking bench for pwm_multi
module tb_pwm_multi;
  localparam int W = 8;
  localparam int C = 4;
  localparam int P = 8;
  logic Clock = 1'b0;
  logic Resetn = 1'b0;
  logic Enable = 1'b0;
  logic Center = 1'b0;
  logic Load = 1'b0;
  logic [P-1:0] Prescale = '0;
  logic [W-1:0] Top = '0;
  logic [C*W-1:0] Duty = '0;
  logic [C-1:0] Y;
  logic [W-1:0] Q;
  logic PeriodStart, Pending;
  int checks = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  pwm_multi #(.WIDTH(W), .CHANNELS(C), .PRE_W(P)) dut (
    .Clock(Clock), .Resetn(Resetn), .Enable(Enable), .Prescale(Prescale), .Top(Top),
    .Center(Center), .Duty(Duty), .Load(Load), .Y(Y), .Q(Q),
    .PeriodStart(PeriodStart), .Pending(Pending)
  );

  task automatic wait_ps(output int n);
    n = 0;
    while (PeriodStart !== 1'b1 && n < 40) begin
      @(negedge Clock);
      n++;
    end
  endtask

  task automatic restart_cfg(input logic [W-1:0] top, input logic center, input logic [C*W-1:0] duty,
                             input logic [P-1:0] pre, output int n);
    Enable = 1'b0; Top = top; Center = center; Duty = duty; Prescale = pre; Load = 1'b1;
    @(negedge Clock);
    Load = 1'b0; Enable = 1'b1;
    wait_ps(n);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge Clock);
    checks++; if (Q !== 8'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", Q); end
    checks++; if (Y !== 4'b0000) begin failures++; $display("FAIL reset_y got=%b exp=0000", Y); end
    checks++; if (PeriodStart !== 1'b0) begin failures++; $display("FAIL reset_ps got=%b exp=0", PeriodStart); end
    checks++; if (Pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", Pending); end
    Resetn = 1'b1;
    @(negedge Clock);
    checks++; if (Q !== 8'd0) begin failures++; $display("FAIL idle_q got=%0d exp=0", Q); end
  endtask

  task automatic test_edge;
    int n, hi;
    logic [C-1:0] ey;
    restart_cfg(8'd9, 1'b0, {8'd0, 8'd10, 8'd0, 8'd3}, 8'd0, n);
    checks++; if (n !== 1) begin failures++; $display("FAIL edge_first_boundary got=%0d exp=1", n); end
    hi = 0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge Clock);
      ey = (k == 0) ? 4'b0000 : {1'b0, 1'b1, 1'b0, 1'(((k - 1) % 10) < 3)};
      if (k >= 1 && k <= 10 && Y[0]) hi++;
      checks++; if (Q !== 8'(k % 10)) begin failures++; $display("FAIL edge_q k=%0d got=%0d exp=%0d", k, Q, k % 10); end
      checks++; if (PeriodStart !== 1'((k % 10) == 0)) begin failures++; $display("FAIL edge_ps k=%0d got=%b", k, PeriodStart); end
      checks++; if (Y !== ey) begin failures++; $display("FAIL edge_y k=%0d got=%b exp=%b", k, Y, ey); end
    end
    checks++; if (hi !== 3) begin failures++; $display("FAIL edge_y0_high got=%0d exp=3", hi); end
  endtask

  task automatic test_prescale;
    int n, hi;
    restart_cfg(8'd3, 1'b0, {8'd0, 8'd0, 8'd0, 8'd2}, 8'd2, n);
    checks++; if (n !== 3) begin failures++; $display("FAIL pre_first_boundary got=%0d exp=3", n); end
    hi = 0;
    for (int k = 0; k < 25; k++) begin
      if (k > 0) @(negedge Clock);
      checks++; if (Q !== 8'((k / 3) % 4)) begin failures++; $display("FAIL pre_q k=%0d got=%0d exp=%0d", k, Q, (k / 3) % 4); end
      checks++; if (PeriodStart !== 1'((k % 12) == 0)) begin failures++; $display("FAIL pre_ps k=%0d got=%b", k, PeriodStart); end
      if (k >= 1) begin
        if (k <= 12 && Y[0]) hi++;
        checks++; if (Y[0] !== 1'((((k - 1) / 3) % 4) < 2)) begin failures++; $display("FAIL pre_y0 k=%0d got=%b", k, Y[0]); end
      end
    end
    checks++; if (hi !== 6) begin failures++; $display("FAIL pre_y0_high got=%0d exp=6", hi); end
  endtask

  task automatic test_center;
    int n, hi;
    logic [7:0] ysq;
    logic [C-1:0] ey;
    int qs [8] = '{0, 1, 2, 3, 4, 3, 2, 1};
    ysq = 8'b1100_0011;
    restart_cfg(8'd4, 1'b1, {8'd0, 8'd0, 8'd4, 8'd2}, 8'd0, n);
    checks++; if (n !== 1) begin failures++; $display("FAIL ctr_first_boundary got=%0d exp=1", n); end
    hi = 0;
    for (int k = 0; k < 25; k++) begin
      if (k > 0) @(negedge Clock);
      checks++; if (Q !== 8'(qs[k % 8])) begin failures++; $display("FAIL ctr_q k=%0d got=%0d exp=%0d", k, Q, qs[k % 8]); end
      checks++; if (PeriodStart !== 1'((k % 8) == 0)) begin failures++; $display("FAIL ctr_ps k=%0d got=%b", k, PeriodStart); end
      if (k >= 1) begin
        ey = {1'b0, 1'b0, 1'b1, ysq[(k - 1) % 8]};
        if (k <= 8 && Y[0]) hi++;
        checks++; if (Y !== ey) begin failures++; $display("FAIL ctr_y k=%0d got=%b exp=%b", k, Y, ey); end
      end
    end
    checks++; if (hi !== 4) begin failures++; $display("FAIL ctr_y0_high got=%0d exp=4", hi); end
  endtask

  task automatic test_load_mid;
    int n, m, dact;
    logic [7:0] dv;
    restart_cfg(8'd9, 1'b0, {8'd0, 8'd0, 8'd0, 8'd3}, 8'd0, n);
    checks++; if (n !== 1) begin failures++; $display("FAIL load_first_boundary got=%0d exp=1", n); end
    for (int k = 1; k <= 35; k++) begin
      m = k - 1;
      dv = (m == 3) ? 8'd7 : (m == 14) ? 8'd5 : 8'd1;
      Load = (m == 3 || m == 14 || m == 19);
      Duty = {24'd0, dv};
      @(negedge Clock);
      dact = (k <= 10) ? 3 : (k <= 20) ? 7 : (k <= 30) ? 5 : 1;
      checks++; if (Y[0] !== 1'(((k - 1) % 10) < dact)) begin failures++; $display("FAIL load_y0 k=%0d got=%b duty=%0d", k, Y[0], dact); end
      checks++; if (Pending !== 1'((k >= 4 && k <= 9) || (k >= 15 && k <= 29))) begin failures++; $display("FAIL load_pending k=%0d got=%b", k, Pending); end
      checks++; if (PeriodStart !== 1'((k % 10) == 0)) begin failures++; $display("FAIL load_ps k=%0d got=%b", k, PeriodStart); end
    end
    Load = 1'b0;
  endtask

  task automatic test_enable_drop;
    int n;
    restart_cfg(8'd9, 1'b0, {8'd0, 8'd0, 8'd0, 8'd3}, 8'd0, n);
    checks++; if (n !== 1) begin failures++; $display("FAIL en_first_boundary got=%0d exp=1", n); end
    repeat (2) @(negedge Clock);
    checks++; if (Q !== 8'd2 || Y[0] !== 1'b1) begin failures++; $display("FAIL en_pre q=%0d y0=%b exp q=2 y0=1", Q, Y[0]); end
    Enable = 1'b0; Load = 1'b1; Duty = {24'd0, 8'd6};
    @(negedge Clock);
    Load = 1'b0;
    checks++; if (Q !== 8'd0) begin failures++; $display("FAIL en_off_q got=%0d exp=0", Q); end
    checks++; if (Y !== 4'b0000) begin failures++; $display("FAIL en_off_y got=%b exp=0000", Y); end
    checks++; if (Pending !== 1'b1) begin failures++; $display("FAIL en_off_pending got=%b exp=1", Pending); end
    repeat (3) @(negedge Clock);
    checks++; if (Q !== 8'd0 || Y !== 4'b0000 || PeriodStart !== 1'b0) begin failures++; $display("FAIL en_idle q=%0d y=%b ps=%b exp 0", Q, Y, PeriodStart); end
    Enable = 1'b1;
    @(negedge Clock);
    checks++; if (Q !== 8'd0 || PeriodStart !== 1'b1) begin failures++; $display("FAIL en_restart q=%0d ps=%b exp q=0 ps=1", Q, PeriodStart); end
    checks++; if (Pending !== 1'b0) begin failures++; $display("FAIL en_restart_pending got=%b exp=0", Pending); end
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clock);
      checks++; if (Q !== 8'(k % 10)) begin failures++; $display("FAIL en_q k=%0d got=%0d exp=%0d", k, Q, k % 10); end
      checks++; if (Y[0] !== 1'((k - 1) < 6)) begin failures++; $display("FAIL en_y0 k=%0d got=%b", k, Y[0]); end
    end
  endtask

  task automatic test_async_reset;
    @(negedge Clock);
    Load = 1'b1; Duty = {24'd0, 8'd4};
    @(negedge Clock);
    Load = 1'b0;
    checks++; if (Y[0] !== 1'b1 || Pending !== 1'b1 || Q !== 8'd2) begin failures++; $display("FAIL ares_pre y0=%b pend=%b q=%0d exp 1 1 2", Y[0], Pending, Q); end
    #2 Resetn = 1'b0;
    #1;
    checks++; if (Q !== 8'd0) begin failures++; $display("FAIL ares_q got=%0d exp=0", Q); end
    checks++; if (Y !== 4'b0000) begin failures++; $display("FAIL ares_y got=%b exp=0000", Y); end
    checks++; if (PeriodStart !== 1'b0 || Pending !== 1'b0) begin failures++; $display("FAIL ares_flags ps=%b pend=%b exp 0 0", PeriodStart, Pending); end
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    checks++; if (Q !== 8'd1 || PeriodStart !== 1'b0) begin failures++; $display("FAIL ares_resume q=%0d ps=%b exp q=1 ps=0", Q, PeriodStart); end
  endtask

  initial begin
    test_reset;
    test_edge;
    test_prescale;
    test_center;
    test_load_mid;
    test_enable_drop;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
